// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding,
// default bus timeout and the value returned by a failed load.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default number of WAIT cycles before an unanswered request is abandoned.
  localparam int TIMEOUT_DEF = 15;

  // A failed load returns all zeros; replicate this bit to the data width.
  localparam logic ERR_RDATA_BIT = 1'b0;

endpackage

// File: rtl/bus_timer.sv
// Saturating WAIT-cycle counter for the memory bridge. 'expired' flags the
// last permitted WAIT cycle so the FSM can abandon the request on that edge.
module bus_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles; clear has priority and the count sticks at TIMEOUT.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the single-cycle core's load/store into a
// req/ack bus transaction and stalls the core until it finishes, times out,
// or is rejected for misalignment.
module dmem_bridge
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              stall,
  output logic              err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack
);

  localparam logic [DATA_W-1:0] ERR_RDATA = {DATA_W{ERR_RDATA_BIT}};

  state_t state;
  logic   access;
  logic   aligned;
  logic   expired;

  assign access  = memread | memwrite;
  assign aligned = (addr[1:0] == 2'b00);

  // Timer runs only while waiting for an ack and restarts from every IDLE.
  bus_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == IDLE),
    .enable  ((state == WAIT) && !bus_ack),
    .expired (expired)
  );

  // Freeze the core from the request cycle until DONE; gating with reset
  // makes stall fall the instant reset asserts, even with memread held high.
  assign stall = reset && (((state == IDLE) && access) || (state == WAIT));

  // Transaction FSM with registered bus outputs, result and error flag.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: capture registers are reset too, so the bus never presents
    // unknown address/data values after power-up.
    if (!reset) begin
      state     <= IDLE;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      readdata  <= ERR_RDATA;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (access) begin
            if (aligned) begin
              // A simultaneous read+write proceeds as a store.
              bus_addr  <= addr;
              bus_wdata <= writedata;
              bus_we    <= memwrite;
              bus_req   <= 1'b1;
              state     <= WAIT;
            end else begin
              err      <= 1'b1;
              readdata <= ERR_RDATA;
              state    <= DONE;
            end
          end
        end
        WAIT: begin
          // The ack outranks a timeout that lands in the same cycle.
          if (bus_ack) begin
            if (!bus_we) begin
              readdata <= bus_rdata;
            end
            bus_req <= 1'b0;
            err     <= 1'b0;
            state   <= DONE;
          end else if (expired) begin
            if (!bus_we) begin
              readdata <= ERR_RDATA;
            end
            bus_req <= 1'b0;
            err     <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          err     <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: the driver pushes the expected result of
// each access; an independent monitor measures stall/request lengths and
// checks the result when the access retires (stall falls).
module tb_dmem_bridge;
  import mem_pkg::*;

  localparam int TMO = 15;

  logic        clk;
  logic        reset;
  logic        memread;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          stall_n;
    int          req_n;
    logic        we;
    logic [31:0] baddr;
    logic [31:0] bwdata;
  } exp_t;

  exp_t q[$];

  dmem_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memread   (memread),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .stall     (stall),
    .err       (err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one access; the responder acks in WAIT cycle ack_n (0 = never).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_n,
                        input logic [31:0] rv, input exp_t e);
    int w;
    bit done;
    q.push_back(e);
    @(posedge clk); #1;
    memread   = rd;
    memwrite  = wr;
    addr      = a;
    writedata = wd;
    bus_rdata = rv;
    w    = 0;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        w++;
        bus_ack = (w == ack_n);
      end else begin
        done = 1;
      end
    end
    bus_ack  = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    if (!done) check("access_cycle_budget", 32'd0, 32'd1);
  endtask

  // Monitor: measure each access and compare it against the scoreboard.
  initial begin : monitor
    int          stall_n;
    int          req_n;
    bit          prev_stall;
    bit          stable;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    exp_t        e;
    stall_n = 0; req_n = 0; prev_stall = 0; stable = 1;
    cap_we = 0; cap_addr = 0; cap_wdata = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_n = 0; req_n = 0; prev_stall = 0; stable = 1;
      end else begin
        if (bus_req) begin
          if (req_n == 0) begin
            cap_we = bus_we; cap_addr = bus_addr; cap_wdata = bus_wdata;
          end else if (bus_we !== cap_we || bus_addr !== cap_addr || bus_wdata !== cap_wdata) begin
            stable = 0;
          end
          req_n++;
        end
        if (stall) begin
          stall_n++;
        end else if (prev_stall) begin
          if (q.size() == 0) begin
            check("unexpected_retire", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            check("err", {31'd0, err}, {31'd0, e.err});
            check("readdata", readdata, e.rdata);
            check("stall_cycles", stall_n, e.stall_n);
            check("req_cycles", req_n, e.req_n);
            if (e.req_n > 0) begin
              check("bus_we", {31'd0, cap_we}, {31'd0, e.we});
              check("bus_addr", cap_addr, e.baddr);
              if (e.we) check("bus_wdata", cap_wdata, e.bwdata);
              check("bus_stable", {31'd0, stable}, 32'd1);
            end
          end
          stall_n = 0; req_n = 0; stable = 1;
        end
        prev_stall = stall;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    exp_t e;
    reset = 1'b0; memread = 0; memwrite = 0; addr = 0; writedata = 0;
    bus_rdata = 0; bus_ack = 0;
    #12;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    #11 reset = 1'b1;

    // Load, ack in WAIT cycle 1.
    e = '{1'b0, 32'hCAFEF00D, 2, 1, 1'b0, 32'h10, 32'h0};
    access(1, 0, 32'h10, 32'h0, 1, 32'hCAFEF00D, e);
    // Store, ack in WAIT cycle 4; readdata untouched despite bus_rdata.
    e = '{1'b0, 32'hCAFEF00D, 5, 4, 1'b1, 32'h20, 32'h12345678};
    access(0, 1, 32'h20, 32'h12345678, 4, 32'hDEADBEEF, e);
    // Misaligned load: no request, one stall cycle, zeroed data.
    e = '{1'b1, 32'h0, 1, 0, 1'b0, 32'h0, 32'h0};
    access(1, 0, 32'h13, 32'h0, 1, 32'h77777777, e);
    // Load to refill readdata before the timeout test.
    e = '{1'b0, 32'h0BADC0DE, 3, 2, 1'b0, 32'h30, 32'h0};
    access(1, 0, 32'h30, 32'h0, 2, 32'h0BADC0DE, e);
    // Load never acked: 15 request cycles, err and zero data.
    e = '{1'b1, 32'h0, TMO + 1, TMO, 1'b0, 32'h40, 32'h0};
    access(1, 0, 32'h40, 32'h0, 0, 32'h99999999, e);
    // Ack lands on the timeout cycle: ack wins.
    e = '{1'b0, 32'h55AA55AA, TMO + 1, TMO, 1'b0, 32'h44, 32'h0};
    access(1, 0, 32'h44, 32'h0, TMO, 32'h55AA55AA, e);
    // Read and write together: proceeds as a store.
    e = '{1'b0, 32'h55AA55AA, 3, 2, 1'b1, 32'h48, 32'hA5A5A5A5};
    access(1, 1, 32'h48, 32'hA5A5A5A5, 2, 32'h11112222, e);
    // Store timing out: err set, readdata kept.
    e = '{1'b1, 32'h55AA55AA, TMO + 1, TMO, 1'b1, 32'h4C, 32'h01020304};
    access(0, 1, 32'h4C, 32'h01020304, 0, 32'h0, e);

    // Stray ack while idle changes nothing.
    @(posedge clk); #1;
    bus_rdata = 32'hFFFF0000;
    bus_ack   = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    check("stray_readdata", readdata, 32'h55AA55AA);
    check("stray_bus_req", {31'd0, bus_req}, 32'd0);
    check("stray_err", {31'd0, err}, 32'd0);
    check("stray_state", {30'd0, dut.state}, {30'd0, IDLE});

    // Reset asserted mid-WAIT, away from any clock edge.
    @(posedge clk); #1;
    memread = 1; addr = 32'h50;
    repeat (3) @(posedge clk);
    #3;
    check("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    check("async_rst_err", {31'd0, err}, 32'd0);
    memread = 0;
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_state", {30'd0, dut.state}, {30'd0, IDLE});
    check("post_rst_bus_req", {31'd0, bus_req}, 32'd0);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Bridges the datapath's data-memory port to an external word-addressed memory bus with a req/ack handshake. It turns the single-cycle core's memory access into a multi-cycle transaction and asserts `stall` to freeze the PC register and register-file write until the access completes. It is the consumer of the datapath's `aluout` and `writedata`, and the producer of its `readdata`.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 15: maximum WAIT cycles before the transaction is abandoned.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `memread`, in, 1: load request from the controller.
- `memwrite`, in, 1: store request from the controller.
- `addr`, in, ADDR_W: byte address (datapath `aluout`).
- `writedata`, in, DATA_W: store data.
- `readdata`, out, DATA_W: registered load result to the datapath result mux.
- `stall`, out, 1: hold PC and suppress register-file write while high.
- `err`, out, 1: access failed (misaligned or timeout); valid in DONE only.
- `bus_req`, out, 1: transaction request, registered.
- `bus_we`, out, 1: 1 = write, 0 = read.
- `bus_addr`, out, ADDR_W: word-aligned address, captured at request.
- `bus_wdata`, out, DATA_W: captured store data.
- `bus_rdata`, in, DATA_W: read data, valid with `bus_ack`.
- `bus_ack`, in, 1: one-cycle completion strobe.

## Operation
- States are IDLE, WAIT and DONE.
- `stall` = (IDLE && (memread || memwrite)) || WAIT. It is combinational and low in DONE.
- IDLE with an access and `addr[1:0]==0`:
  - Capture `addr`, `writedata`, and `bus_we = memwrite`.
  - Set `bus_req=1`, clear the timeout counter, and go to WAIT.
- IDLE with an access and `addr[1:0]!=0`:
  - No bus request is issued.
  - Go to DONE with `err=1` and `readdata=0`.
- `memread && memwrite` together: the write wins and proceeds as a store; `readdata` is not updated.
- WAIT with `bus_ack`:
  - Latch `bus_rdata` into `readdata` on reads only; a write leaves `readdata` unchanged.
  - Drop `bus_req`, set `err=0`, and go to DONE.
- WAIT without `bus_ack`: the counter increments. When the counter equals `TIMEOUT-1`, drop `bus_req` and go to DONE with `err=1`.
  - Reads also set `readdata=0`.
- `bus_ack` and timeout in the same cycle: the ack wins and `err=0`.
- DONE always goes to IDLE after one cycle. The instruction retires at this edge, which also clears `err`.
- `bus_ack` outside WAIT is ignored.
- `bus_addr`, `bus_wdata` and `bus_we` hold stable from request until ack or timeout. They may change only in IDLE.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values:
  - state = IDLE.
  - `bus_req`, `bus_we`, `err`, `stall` = 0.
  - `readdata`, `bus_addr`, `bus_wdata` = 0.
- A reset assertion mid-transaction drops `bus_req` immediately (asynchronously) and aborts the transaction; there is no retry.
- Aligned access whose ack arrives in the n-th WAIT cycle (n ≥ 1):
  - `stall` is high for n+1 cycles.
  - The instruction occupies n+2 cycles.
  - `readdata` is valid from the DONE cycle onward and holds until the next completed read.
- A misaligned access stalls for exactly 1 cycle.
- A timed-out access stalls for TIMEOUT+1 cycles.
- Back-to-back accesses: the next access enters IDLE one cycle after DONE. `bus_req` is low for at least 2 cycles between transactions.

## Structure
- Shared package `mem_pkg` holds:
  - The state enum (IDLE/WAIT/DONE).
  - Default `TIMEOUT`.
  - The error read value (all zeros).
- One sub-module, `bus_timer`, is natural: a saturating counter with clear/enable and a `expired` output compared against `TIMEOUT-1`.
- FSM and capture registers stay in `dmem_bridge`.

## Test plan
- Reset release, then a load at `addr=0x10` with ack in WAIT cycle 1 and `bus_rdata=0xCAFEF00D`. Expect `stall` high 2 cycles, `bus_addr=0x10`, `bus_we=0`, `readdata=0xCAFEF00D` in DONE, and `err=0`.
- Store at `0x20` with `writedata=0x12345678`, ack after 4 WAIT cycles. Expect `bus_we=1` and `bus_wdata` stable for 4 cycles, `stall` high 5 cycles, and `readdata` unchanged.
- Load at `0x13` (misaligned). Expect no `bus_req`, `stall` for 1 cycle, and `err=1`, `readdata=0` in DONE.
- Load with no ack and `TIMEOUT=15`. Expect `bus_req` high exactly 15 cycles, then DONE with `err=1` and `readdata=0`.
- Assert ack in the same cycle as the timeout, and separately assert `memread` and `memwrite` together. Expect `err=0` with data latched in the first case, and a write transaction in the second.
- Pull `reset` low during WAIT. Expect `bus_req`, `stall` and `err` to drop at once without waiting for a clock, and state IDLE after release. A stray `bus_ack` in IDLE produces no change.
